// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scheduler
//  Brief    : Hazard controller for a 5-stage RV32I pipeline. Keeps a shadow
//             copy of the EX/MEM/WB destinations and op types, and derives
//             stage enables, flushes and operand-forwarding selects from it.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_scheduler #(
   parameter int         REG_AW    = 5,
   parameter logic [1:0] OPT_NONE  = 2'd0,
   parameter logic [1:0] OPT_ALU   = 2'd1,
   parameter logic [1:0] OPT_LOAD  = 2'd2,
   parameter logic [1:0] OPT_STORE = 2'd3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic              rs1use,
   input  logic              rs2use,
   input  logic [1:0]        hazard_optype,
   input  logic              Branch,
   input  logic              mem_stall,
   output logic              PC_EN_IF,
   output logic              reg_FD_EN,
   output logic              reg_FD_flush,
   output logic              reg_DE_EN,
   output logic              reg_DE_flush,
   output logic              reg_EM_EN,
   output logic              reg_MW_EN,
   output logic [1:0]        forward_ctrl_A,
   output logic [1:0]        forward_ctrl_B,
   output logic              forward_ctrl_ls
);

   // Forwarding select encodings
   localparam logic [1:0] c_FWD_RF      = 2'd0;
   localparam logic [1:0] c_FWD_EX_ALU  = 2'd1;
   localparam logic [1:0] c_FWD_MEM_ALU = 2'd2;
   localparam logic [1:0] c_FWD_MEM_LD  = 2'd3;

   // Shadow pipeline slots
   logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
   logic [1:0]        ex_op_q,  ex_op_d;
   logic              ex_ls_q,  ex_ls_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic [1:0]        mem_op_q, mem_op_d;
   logic              mem_ls_q, mem_ls_d;
   logic [REG_AW-1:0] wb_rd_q,  wb_rd_d;
   logic [1:0]        wb_op_q,  wb_op_d;

   logic w_ex_wr, w_mem_wr, w_wb_load;
   logic w_hit_a_ex, w_hit_b_ex, w_hit_a_mem, w_hit_b_mem;
   logic w_ex_load, w_store_exc, w_ld_stall;
   logic [1:0] w_fwd_a, w_fwd_b;

   // Hit detection against the shadow slots and load-use stall decision
   always_comb begin
      w_ex_wr     = ((ex_op_q == OPT_ALU) || (ex_op_q == OPT_LOAD)) && (ex_rd_q != '0);
      w_mem_wr    = ((mem_op_q == OPT_ALU) || (mem_op_q == OPT_LOAD)) && (mem_rd_q != '0);
      w_wb_load   = (wb_op_q == OPT_LOAD) && (wb_rd_q != '0);
      w_hit_a_ex  = rs1use && w_ex_wr  && (ex_rd_q  == rs1_addr);
      w_hit_b_ex  = rs2use && w_ex_wr  && (ex_rd_q  == rs2_addr);
      w_hit_a_mem = rs1use && w_mem_wr && (mem_rd_q == rs1_addr);
      w_hit_b_mem = rs2use && w_mem_wr && (mem_rd_q == rs2_addr);
      w_ex_load   = (ex_op_q == OPT_LOAD);
      // A store whose data (rs2) alone depends on the load in EX can take the
      // loaded value later, from WB into MEM, so it does not need to wait.
      w_store_exc = (hazard_optype == OPT_STORE) && w_hit_b_ex && w_ex_load && !w_hit_a_ex;
      w_ld_stall  = w_ex_load && (w_hit_a_ex || (w_hit_b_ex && !w_store_exc));
   end

   // Operand source selection; the youngest producer (EX) shadows MEM
   always_comb begin
      w_fwd_a = c_FWD_RF;
      w_fwd_b = c_FWD_RF;
      if (w_hit_a_ex) begin
         if (ex_op_q == OPT_ALU) w_fwd_a = c_FWD_EX_ALU;
      end else if (w_hit_a_mem) begin
         w_fwd_a = (mem_op_q == OPT_ALU) ? c_FWD_MEM_ALU : c_FWD_MEM_LD;
      end
      if (w_hit_b_ex) begin
         if (ex_op_q == OPT_ALU) w_fwd_b = c_FWD_EX_ALU;
      end else if (w_hit_b_mem) begin
         w_fwd_b = (mem_op_q == OPT_ALU) ? c_FWD_MEM_ALU : c_FWD_MEM_LD;
      end
   end

   // Output drive; everything is held low while reset is asserted
   always_comb begin
      PC_EN_IF        = 1'b0;
      reg_FD_EN       = 1'b0;
      reg_FD_flush    = 1'b0;
      reg_DE_EN       = 1'b0;
      reg_DE_flush    = 1'b0;
      reg_EM_EN       = 1'b0;
      reg_MW_EN       = 1'b0;
      forward_ctrl_A  = c_FWD_RF;
      forward_ctrl_B  = c_FWD_RF;
      forward_ctrl_ls = 1'b0;
      if (rstn) begin
         forward_ctrl_A  = w_fwd_a;
         forward_ctrl_B  = w_fwd_b;
         forward_ctrl_ls = mem_ls_q && w_wb_load;
         if (!mem_stall) begin
            PC_EN_IF     = !w_ld_stall;
            reg_FD_EN    = !w_ld_stall;
            reg_FD_flush = Branch && !w_ld_stall;
            reg_DE_flush = w_ld_stall;
            reg_DE_EN    = 1'b1;
            reg_EM_EN    = 1'b1;
            reg_MW_EN    = 1'b1;
         end
      end
   end

   // Shadow pipeline advance; frozen while memory stalls
   always_comb begin
      ex_rd_d  = ex_rd_q;
      ex_op_d  = ex_op_q;
      ex_ls_d  = ex_ls_q;
      mem_rd_d = mem_rd_q;
      mem_op_d = mem_op_q;
      mem_ls_d = mem_ls_q;
      wb_rd_d  = wb_rd_q;
      wb_op_d  = wb_op_q;
      if (!mem_stall) begin
         wb_rd_d  = mem_rd_q;
         wb_op_d  = mem_op_q;
         mem_rd_d = ex_rd_q;
         mem_op_d = ex_op_q;
         mem_ls_d = ex_ls_q;
         if (w_ld_stall) begin
            ex_rd_d = '0;
            ex_op_d = OPT_NONE;
            ex_ls_d = 1'b0;
         end else begin
            ex_rd_d = rd_addr;
            ex_op_d = hazard_optype;
            ex_ls_d = w_store_exc;
         end
      end
   end

   // Shadow state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_rd_q  <= '0;
         ex_op_q  <= OPT_NONE;
         ex_ls_q  <= 1'b0;
         mem_rd_q <= '0;
         mem_op_q <= OPT_NONE;
         mem_ls_q <= 1'b0;
         wb_rd_q  <= '0;
         wb_op_q  <= OPT_NONE;
      end else begin
         ex_rd_q  <= ex_rd_d;
         ex_op_q  <= ex_op_d;
         ex_ls_q  <= ex_ls_d;
         mem_rd_q <= mem_rd_d;
         mem_op_q <= mem_op_d;
         mem_ls_q <= mem_ls_d;
         wb_rd_q  <= wb_rd_d;
         wb_op_q  <= wb_op_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scheduler
//  Brief    : Self-checking bench for hazard_scheduler; a queue-based model of
//             the in-flight instructions predicts every output each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_scheduler;

   localparam logic [1:0] NONE = 2'd0, ALU = 2'd1, LOAD = 2'd2, STORE = 2'd3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [4:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
   logic rs1use = 1'b0, rs2use = 1'b0, Branch = 1'b0, mem_stall = 1'b0;
   logic [1:0] hazard_optype = NONE;
   logic PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush;
   logic reg_EM_EN, reg_MW_EN, forward_ctrl_ls;
   logic [1:0] forward_ctrl_A, forward_ctrl_B;

   int nvec = 0;
   int nerr = 0;

   hazard_scheduler dut (
      .clk(clk), .rstn(rstn),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1use(rs1use), .rs2use(rs2use), .hazard_optype(hazard_optype),
      .Branch(Branch), .mem_stall(mem_stall),
      .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
      .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
      .reg_EM_EN(reg_EM_EN), .reg_MW_EN(reg_MW_EN),
      .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
      .forward_ctrl_ls(forward_ctrl_ls)
   );

   always #5 clk = ~clk;

   wire [11:0] dut_out = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush,
                          reg_EM_EN, reg_MW_EN, forward_ctrl_A, forward_ctrl_B,
                          forward_ctrl_ls};

   // ---------------- reference model: list of instructions past ID ----------
   typedef struct packed {
      logic [4:0] rd;
      logic [1:0] op;
      logic       st_from_ld;   // store whose data comes from the load just ahead
   } instr_t;

   instr_t pipe[$];   // [0]=youngest (EX), [1]=MEM, [2]=WB

   task automatic model_reset();
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back('0);
   endtask

   function automatic logic produces(instr_t r, logic [4:0] a);
      return ((r.op == ALU) || (r.op == LOAD)) && (r.rd != 5'd0) && (r.rd == a);
   endfunction

   function automatic logic m_stall();
      logic dep1, dep2;
      dep1 = rs1use && produces(pipe[0], rs1_addr) && (pipe[0].op == LOAD);
      dep2 = rs2use && produces(pipe[0], rs2_addr) && (pipe[0].op == LOAD);
      return dep1 || (dep2 && (hazard_optype != STORE));
   endfunction

   function automatic logic [1:0] m_src(logic u, logic [4:0] a);
      if (u && produces(pipe[0], a)) return (pipe[0].op == ALU) ? 2'd1 : 2'd0;
      if (u && produces(pipe[1], a)) return (pipe[1].op == ALU) ? 2'd2 : 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [11:0] model_out();
      logic s, run;
      if (!rstn) return 12'd0;
      s   = m_stall();
      run = !mem_stall;
      return {run && !s, run && !s, run && Branch && !s, run, run && s, run, run,
              m_src(rs1use, rs1_addr), m_src(rs2use, rs2_addr), pipe[1].st_from_ld};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] d, input logic u1, input logic u2,
                        input logic [1:0] op, input logic br, input logic ms);
      @(negedge clk);
      rstn = r;
      if (!r) model_reset();
      rs1_addr = a1; rs2_addr = a2; rd_addr = d;
      rs1use = u1; rs2use = u2; hazard_optype = op;
      Branch = br; mem_stall = ms;
      #1;
   endtask

   task automatic nop();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b0, 1'b0);
   endtask

   task automatic tick();
      instr_t n;
      @(posedge clk);
      if (rstn && !mem_stall) begin
         if (m_stall()) n = '0;
         else begin
            n.rd = rd_addr;
            n.op = hazard_optype;
            n.st_from_ld = (hazard_optype == STORE) && rs2use &&
                           produces(pipe[0], rs2_addr) && (pipe[0].op == LOAD);
         end
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      model_reset();
      drive(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, LOAD, 1'b1, 1'b0);
      nvec++;
      if (dut_out !== 12'd0) begin
         nerr++; $display("FAIL reset_outputs: got %h expected %h", dut_out, 12'd0);
      end
      tick();
      nop();
      nvec++;
      if (dut_out !== model_out() || PC_EN_IF !== 1'b1 || reg_FD_EN !== 1'b1) begin
         nerr++; $display("FAIL reset_release: got %h expected %h", dut_out, model_out());
      end
      tick();
   endtask

   task automatic test_alu_chain();
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, ALU, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, ALU, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || forward_ctrl_A !== 2'd1 || forward_ctrl_B !== 2'd1) begin
         nerr++; $display("FAIL alu_ex_fwd: got %h expected %h", dut_out, model_out());
      end
      tick();
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, ALU, 1'b0, 1'b0); tick();
      nop(); tick();
      drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, ALU, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || forward_ctrl_A !== 2'd2 || forward_ctrl_B !== 2'd2) begin
         nerr++; $display("FAIL alu_mem_fwd: got %h expected %h", dut_out, model_out());
      end
      tick();
   endtask

   task automatic test_load_use();
      drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, LOAD, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b1, ALU, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || PC_EN_IF !== 1'b0 || reg_FD_EN !== 1'b0 ||
          reg_DE_flush !== 1'b1) begin
         nerr++; $display("FAIL load_use_stall: got %h expected %h", dut_out, model_out());
      end
      tick();
      drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b1, ALU, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || forward_ctrl_A !== 2'd3 || PC_EN_IF !== 1'b1) begin
         nerr++; $display("FAIL load_use_resume: got %h expected %h", dut_out, model_out());
      end
      tick();
   endtask

   task automatic test_load_store();
      logic [2:0] exp_ls;
      exp_ls = 3'b010;   // ls seen only on the second cycle after the sw
      drive(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, LOAD, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd10, 5'd9, 5'd0, 1'b1, 1'b1, STORE, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || PC_EN_IF !== 1'b1 || forward_ctrl_B !== 2'd0) begin
         nerr++; $display("FAIL store_no_stall: got %h expected %h", dut_out, model_out());
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         nop();
         nvec++;
         if (dut_out !== model_out() || forward_ctrl_ls !== exp_ls[i]) begin
            nerr++; $display("FAIL store_ls_fwd cyc %0d: got %h expected %h", i, dut_out, model_out());
         end
         tick();
      end
   endtask

   task automatic test_branch();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, NONE, 1'b1, 1'b0);
      nvec++;
      if (dut_out !== model_out() || reg_FD_flush !== 1'b1) begin
         nerr++; $display("FAIL branch_flush: got %h expected %h", dut_out, model_out());
      end
      tick();
      drive(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, LOAD, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1, NONE, 1'b1, 1'b0);
      nvec++;
      if (dut_out !== model_out() || reg_FD_flush !== 1'b0 || reg_DE_flush !== 1'b1) begin
         nerr++; $display("FAIL branch_stalled: got %h expected %h", dut_out, model_out());
      end
      tick();
      drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b1, NONE, 1'b1, 1'b0);
      nvec++;
      if (dut_out !== model_out() || reg_FD_flush !== 1'b1 || forward_ctrl_A !== 2'd3) begin
         nerr++; $display("FAIL branch_retry: got %h expected %h", dut_out, model_out());
      end
      tick();
   endtask

   task automatic test_mem_stall();
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, ALU, 1'b0, 1'b0); tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, ALU, 1'b1, (i < 3));
         nvec++;
         if (dut_out !== model_out() || forward_ctrl_A !== 2'd1 ||
             PC_EN_IF !== (i == 3) || reg_MW_EN !== (i == 3) || reg_FD_flush !== (i == 3)) begin
            nerr++; $display("FAIL mem_stall cyc %0d: got %h expected %h", i, dut_out, model_out());
         end
         tick();
      end
   endtask

   task automatic test_x0();
      drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, ALU, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, LOAD, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || forward_ctrl_A !== 2'd0 || forward_ctrl_B !== 2'd0) begin
         nerr++; $display("FAIL x0_no_fwd: got %h expected %h", dut_out, model_out());
      end
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, ALU, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || PC_EN_IF !== 1'b1 || forward_ctrl_A !== 2'd0) begin
         nerr++; $display("FAIL x0_load_no_stall: got %h expected %h", dut_out, model_out());
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, LOAD, 1'b0, 1'b0); tick();
      drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, ALU, 1'b0, 1'b1); tick();
      drive(1'b0, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, ALU, 1'b0, 1'b1);
      nvec++;
      if (dut_out !== 12'd0) begin
         nerr++; $display("FAIL reset_mid_stall: got %h expected %h", dut_out, 12'd0);
      end
      tick();
      drive(1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b1, ALU, 1'b0, 1'b0);
      nvec++;
      if (dut_out !== model_out() || PC_EN_IF !== 1'b1 || forward_ctrl_A !== 2'd0) begin
         nerr++; $display("FAIL reset_resume: got %h expected %h", dut_out, model_out());
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 63) != 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0));
         nvec++;
         if (dut_out !== model_out()) begin
            nerr++; $display("FAIL random step %0d: got %h expected %h", i, dut_out, model_out());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_load_store();
      test_branch();
      test_mem_stall();
      test_x0();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). Branches resolve in ID.
- Tracks the destination register and hazard op type of in-flight instructions in its own shadow pipeline (EX/MEM/WB slots).
- From that state it produces stage enables, flushes and operand-forwarding selects.
- Inputs come from the ID-stage decoder (rs1use/rs2use/hazard_optype/Branch) and the memory interface.

Parameters:
- REG_AW, 5, register address width
- OPT_NONE, 2'd0, op type: no register write / bubble
- OPT_ALU, 2'd1, op type: result available at end of EX
- OPT_LOAD, 2'd2, op type: result available at end of MEM
- OPT_STORE, 2'd3, op type: no register write

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- rs1_addr  in  REG_AW  ID-stage rs1
- rs2_addr  in  REG_AW  ID-stage rs2
- rd_addr  in  REG_AW  ID-stage rd
- rs1use  in  1  ID instruction reads rs1
- rs2use  in  1  ID instruction reads rs2
- hazard_optype  in  2  ID instruction op type
- Branch  in  1  ID-stage taken branch/jump
- mem_stall  in  1  data memory busy; freeze whole pipeline
- PC_EN_IF  out  1  PC update enable
- reg_FD_EN  out  1  IF/ID enable
- reg_FD_flush  out  1  IF/ID flush
- reg_DE_EN  out  1  ID/EX enable
- reg_DE_flush  out  1  ID/EX flush (bubble)
- reg_EM_EN  out  1  EX/MEM enable
- reg_MW_EN  out  1  MEM/WB enable
- forward_ctrl_A  out  2  rs1 source: 0 regfile, 1 EX ALU out, 2 MEM ALU out, 3 MEM load data
- forward_ctrl_B  out  2  rs2 source, same encoding
- forward_ctrl_ls  out  1  MEM store data taken from WB load data

Behaviour:
- Shadow state: slots EX, MEM and WB, each holding {rd, optype, ls_fwd}. Async reset clears all slots to rd=0, optype=OPT_NONE, ls_fwd=0.
- While rstn=0, all outputs are 0.
- A slot "writes rd" iff optype is ALU or LOAD and rd != 0. x0 never matches.
- hitA_EX: rs1use & EX writes rd & EX.rd == rs1_addr. hitA_MEM, hitB_EX and hitB_MEM are defined the same way.
- Load-use stall (ld_stall), asserted when either holds:
  - hitA_EX with EX.optype=LOAD;
  - hitB_EX with EX.optype=LOAD, unless the ID op is STORE and rs2 is its only hit.
  - In that exception there is no stall. ID's ls_fwd is set when it enters EX.
- forward_ctrl_A:
  - hitA_EX & ALU → 1;
  - else hitA_MEM & ALU → 2;
  - else hitA_MEM & LOAD → 3;
  - else 0.
  - EX has priority over MEM. Same rule for B. Outputs are combinational.
  - The store-rs2 exception case gives forward_ctrl_B=0.
- forward_ctrl_ls = MEM.ls_fwd (store in MEM, producing load in WB).
- With mem_stall=1:
  - all enables are 0 and both flushes are 0;
  - shadow slots hold;
  - overrides everything else.
- With mem_stall=0:
  - PC_EN_IF = reg_FD_EN = ~ld_stall;
  - reg_DE_flush = ld_stall;
  - reg_FD_flush = Branch & ~ld_stall. A stalled branch is re-evaluated next cycle with forwarded operands.
  - reg_DE_EN = reg_EM_EN = reg_MW_EN = 1.
- Shadow update each rising edge when mem_stall=0:
  - WB←MEM; MEM←EX.
  - EX←bubble if ld_stall, else {rd_addr, hazard_optype, ls_fwd_cond}.
- Branch and ld_stall in the same cycle: the stall wins and no flush is issued.
- Reset asserted mid-stall: all state clears immediately. After release the pipeline resumes with no stall and no forwarding.
- Single-cycle stall only; back-to-back load-use chains re-stall per dependent instruction.

Test Plan:
- Reset: rstn=0 → all outputs 0. Release with idle ID (rs*use=0) → PC_EN_IF=1, reg_FD_EN=1, both flushes 0, forwards 0.
- ALU chain: `add x5` then `add x6,x5,x5` next cycle → forward_ctrl_A=B=1. With one instruction gap → A=B=2.
- Load-use: `lw x7` then `add x8,x7,x0` → one cycle with PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1. Next cycle forward_ctrl_A=3 and no stall.
- Load→store data: `lw x9` then `sw x9,0(x10)` → no stall. forward_ctrl_ls=1 exactly two cycles after the sw leaves ID.
- Branch: Branch=1 with no hazard → reg_FD_flush=1 for one cycle. Branch=1 with rs1 hitting a load in EX → reg_FD_flush=0, ld_stall. Flush occurs the following cycle.
- mem_stall=1 for 3 cycles mid ALU chain → all enables 0 and forwards frozen. After release, forwarding resumes with the same values. rd=x0 producer never forwards.
